mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Sequences the MEM stage of the RV32I pipeline. It takes the access fields held by the EX/MEM pipeline register and drives a request/grant/response data-memory bus. It holds the upstream pipeline through a stall while the access is outstanding, then hands formatted load data or the pass-through ALU result to MEM/WB. It also flags misaligned, illegal and timed-out accesses so that no write-back occurs for them.

Parameters:
TIMEOUT_CYCLES, 64, cycles spent in REQ or WAIT before the access is aborted with a bus error (minimum 2)
CNT_W, 7, width of the timeout counter (must hold TIMEOUT_CYCLES)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
read_en_i  in  1  load from EX/MEM
write_en_i  in  1  store from EX/MEM (read_en_i and write_en_i both 1 is illegal)
mem_op_i  in  3  RISC-V funct3 width/sign code
addr_i  in  32  effective address
store_data_i  in  32  rs2 value for stores
result_i  in  32  ALU result
rd_i  in  5  destination register
wb_en_i  in  1  write-back enable
stall_o  out  1  hold EX/MEM and earlier stages
mem_req_o  out  1  bus request
mem_we_o  out  1  1=store
mem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
mem_wdata_o  out  32  lane-replicated store data
mem_be_o  out  4  byte enables
mem_gnt_i  in  1  request accepted
mem_rvalid_i  in  1  load data valid
mem_rdata_i  in  32  load data word
wb_en_o  out  1  write-back enable to MEM/WB
wb_rd_o  out  5  destination register
wb_data_o  out  32  write-back data
misalign_o  out  1  one-cycle pulse, misaligned or illegal mem_op
bus_err_o  out  1  one-cycle pulse, timeout

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE; all outputs 0; latched fields 0; counter 0.
- access = read_en_i | write_en_i.
- Legal mem_op values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000, 001, 010 only.
  - Any other value is illegal.
- Aligned: byte ops are always aligned; half requires addr[0]=0; word requires addr[1:0]=0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, access=0:
  - Combinational pass-through: wb_en_o=wb_en_i, wb_rd_o=rd_i, wb_data_o=result_i.
  - stall_o=0.
- IDLE, access=1 and illegal or misaligned (including read_en_i and write_en_i both 1):
  - misalign_o=1 in the same cycle; wb_en_o=0; stall_o=0; no bus activity; stay in IDLE.
- IDLE, legal aligned access:
  - stall_o=1 combinationally.
  - Latch op, byte offset, we, rd, wb_en, and computed be/wdata/addr.
  - Next state REQ; counter cleared.
- REQ:
  - mem_req_o=1; addr/we/be/wdata held stable until grant; stall_o=1.
  - On mem_gnt_i: store goes to DONE; load goes to WAIT.
  - Load with mem_gnt_i and mem_rvalid_i in the same cycle: capture data and go directly to DONE.
- WAIT:
  - mem_req_o=0; stall_o=1.
  - On mem_rvalid_i: format and capture data, go to DONE.
- Timeout: in REQ or WAIT the counter increments each cycle. When it reaches TIMEOUT_CYCLES-1 without the exiting event, bus_err_o pulses in that cycle, the suppress flag is set, and the next state is DONE.
- DONE:
  - stall_o=0.
  - wb_en_o = latched wb_en & is_load & ~suppress. Stores never write back.
  - wb_rd_o and wb_data_o come from latches.
  - DONE never starts a new access (the EX/MEM contents are still the finished instruction). Next state is IDLE.
- Store formatting:
  - SB: wdata={4{d[7:0]}}, be=0001<<off.
  - SH: wdata={2{d[15:0]}}, be=0011<<off.
  - SW: wdata=d, be=1111.
- Load formatting: select byte/half lane by offset; sign-extend for 000/001; zero-extend for 100/101.
- mem_rvalid_i or mem_gnt_i arriving in IDLE or DONE is ignored.
- Reset mid-access: return to IDLE in the next cycle, mem_req_o drops, and any late response is ignored.
- Latency:
  - Store with grant on the first REQ cycle: stall for 2 cycles.
  - Load with 1-cycle rvalid: stall for 3 cycles.

Decomposition:
- Shared package mem_pkg:
  - funct3 constants: MEM_B=3'b000, MEM_H=3'b001, MEM_W=3'b010, MEM_BU=3'b100, MEM_HU=3'b101.
  - State enum: IDLE, REQ, WAIT, DONE.
- Sub-module lsu_load_align: purely combinational; inputs rdata, op, offset; output 32-bit extended result. Reused by the bench as a reference model.

Test Plan:
- Non-memory op: read_en=write_en=0, result_i=0x1234, rd=5, wb_en=1 -> same cycle wb_data_o=0x1234, wb_rd_o=5, wb_en_o=1, stall_o=0, mem_req_o=0.
- SB: addr=0x1003, store_data=0xAABBCCDD, grant on first REQ cycle -> mem_addr_o=0x1000, mem_be_o=1000, mem_wdata_o=0xDDDDDDDD, stall for 2 cycles, wb_en_o=0 in DONE.
- LB: addr=0x2002, mem_rdata=0x0080_0000, grant then rvalid after 3 cycles -> wb_data_o=0xFFFFFF80; LBU with the same stimulus -> 0x00000080; stall held throughout.
- LH: addr=0x3001 -> misalign_o=1 for one cycle, no mem_req_o, wb_en_o=0, stall_o=0.
- Load with no rvalid -> bus_err_o pulse after TIMEOUT_CYCLES cycles, DONE with wb_en_o=0, then IDLE.
- rst asserted while in WAIT, then rvalid one cycle later -> IDLE, all outputs 0, rvalid ignored, the next non-memory op passes through.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared MEM-stage definitions: funct3 width codes, FSM states,
// and helpers for legality, alignment and store lane formatting.
package mem_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_e;

  function automatic logic op_legal(
    input logic       rd,
    input logic       wr,
    input logic [2:0] op
  );
    logic ok;
    ok = 1'b0;
    if (rd && wr)
      ok = 1'b0;
    else if (wr)
      ok = (op == MEM_B) || (op == MEM_H) ||
           (op == MEM_W);
    else if (rd)
      ok = (op == MEM_B)  || (op == MEM_H)  ||
           (op == MEM_W)  || (op == MEM_BU) ||
           (op == MEM_HU);
    return ok;
  endfunction

  // sz is funct3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic is_aligned(
    input logic [1:0] sz,
    input logic [1:0] off
  );
    logic ok;
    unique case (sz)
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~off[0];
      2'b10:   ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] be_of(
    input logic [1:0] sz,
    input logic [1:0] off
  );
    logic [3:0] be;
    unique case (sz)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_of(
    input logic [1:0]  sz,
    input logic [31:0] d
  );
    logic [31:0] w;
    unique case (sz)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Load lane select and sign/zero extension (combinational).
// Ports: rdata_i word, op_i funct3, off_i byte offset -> data_o.
module lsu_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  op_i,
  input  logic [1:0]  off_i,
  output logic [31:0] data_o
);

  logic [31:0] sh;

  assign sh = rdata_i >> {off_i, 3'b000};

  always_comb begin
    unique case (op_i)
      MEM_B:   data_o = {{24{sh[7]}}, sh[7:0]};
      MEM_BU:  data_o = {24'h0, sh[7:0]};
      MEM_H:   data_o = {{16{sh[15]}}, sh[15:0]};
      MEM_HU:  data_o = {16'h0, sh[15:0]};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: EX/MEM access -> req/gnt/rvalid bus -> MEM/WB.
// Ports: EX/MEM fields in, stall out, data bus, MEM/WB out, error pulses.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_en_i,
  input  logic        write_en_i,
  input  logic [2:0]  mem_op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] result_i,
  input  logic [4:0]  rd_i,
  input  logic        wb_en_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        wb_en_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic        we_q, we_d;
  logic [4:0]  rd_q, rd_d;
  logic        wben_q, wben_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        sup_q, sup_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        access;
  logic        legal;
  logic        tmo;
  logic [31:0] ld_data;

  assign access = read_en_i | write_en_i;
  assign legal  = op_legal(read_en_i, write_en_i, mem_op_i) &
                  is_aligned(mem_op_i[1:0], addr_i[1:0]);
  assign tmo    = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  lsu_load_align u_align (
    .rdata_i (mem_rdata_i),
    .op_i    (op_q),
    .off_i   (off_q),
    .data_o  (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      wben_q  <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      sup_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      off_q   <= off_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      wben_q  <= wben_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sup_q   <= sup_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    off_d   = off_q;
    we_d    = we_q;
    rd_d    = rd_q;
    wben_d  = wben_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sup_d   = sup_q;
    cnt_d   = cnt_q;

    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    wb_en_o     = 1'b0;
    wb_rd_o     = '0;
    wb_data_o   = '0;
    misalign_o  = 1'b0;
    bus_err_o   = 1'b0;

    unique case (state_q)
      IDLE: begin
        wb_rd_o   = rd_i;
        wb_data_o = result_i;
        if (!access) begin
          wb_en_o = wb_en_i;
        end else if (!legal) begin
          misalign_o = 1'b1;
        end else begin
          stall_o = 1'b1;
          op_d    = mem_op_i;
          off_d   = addr_i[1:0];
          we_d    = write_en_i;
          rd_d    = rd_i;
          wben_d  = wb_en_i;
          be_d    = be_of(mem_op_i[1:0], addr_i[1:0]);
          wdata_d = wdata_of(mem_op_i[1:0], store_data_i);
          addr_d  = {addr_i[31:2], 2'b00};
          data_d  = '0;
          sup_d   = 1'b0;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        mem_be_o    = be_q;
        cnt_d       = cnt_q + CNT_W'(1);
        if (mem_gnt_i) begin
          if (we_q) begin
            state_d = DONE;
          end else if (mem_rvalid_i) begin
            data_d  = ld_data;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end else if (tmo) begin
          bus_err_o = 1'b1;
          sup_d     = 1'b1;
          state_d   = DONE;
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (mem_rvalid_i) begin
          data_d  = ld_data;
          state_d = DONE;
        end else if (tmo) begin
          bus_err_o = 1'b1;
          sup_d     = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        // EX/MEM still holds the finished op, so never re-launch here
        wb_en_o   = wben_q & ~we_q & ~sup_q;
        wb_rd_o   = rd_q;
        wb_data_o = data_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // hold every output low while reset is applied
    if (rst) begin
      stall_o     = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      wb_en_o     = 1'b0;
      wb_rd_o     = '0;
      wb_data_o   = '0;
      misalign_o  = 1'b0;
      bus_err_o   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed ops, queued
// expectations, negedge monitor comparing bus and write-back.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read_en = 0, write_en = 0;
  logic [2:0]  mem_op = '0;
  logic [31:0] addr = '0, store_data = '0, result = '0;
  logic [4:0]  rd = '0;
  logic        wb_en = 0;
  logic        stall_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        gnt = 0, rvalid = 0;
  logic [31:0] rdata = '0;
  logic        wb_en_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        misalign_o, bus_err_o;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .read_en_i    (read_en),
    .write_en_i   (write_en),
    .mem_op_i     (mem_op),
    .addr_i       (addr),
    .store_data_i (store_data),
    .result_i     (result),
    .rd_i         (rd),
    .wb_en_i      (wb_en),
    .stall_o      (stall_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_be_o     (mem_be_o),
    .mem_gnt_i    (gnt),
    .mem_rvalid_i (rvalid),
    .mem_rdata_i  (rdata),
    .wb_en_o      (wb_en_o),
    .wb_rd_o      (wb_rd_o),
    .wb_data_o    (wb_data_o),
    .misalign_o   (misalign_o),
    .bus_err_o    (bus_err_o)
  );

  typedef struct {
    string       name;
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
    logic        err;
    int          stalls;
  } wb_exp_t;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  wb_exp_t  wq[$];
  bus_exp_t bq[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic wb_exp_t W(string n, logic en,
      logic [4:0] r, logic [31:0] d,
      logic mis, logic err, int st);
    wb_exp_t e;
    e.name = n; e.en = en; e.rd = r; e.data = d;
    e.mis = mis; e.err = err; e.stalls = st;
    return e;
  endfunction

  function automatic bus_exp_t B(string n, logic we,
      logic [31:0] a, logic [3:0] be, logic [31:0] wd);
    bus_exp_t b;
    b.name = n; b.we = we; b.addr = a;
    b.be = be; b.wdata = wd;
    return b;
  endfunction

  // monitor: compares bus on each new request, write-back on
  // every non-stalled cycle
  initial begin
    int       run;
    logic     err_seen;
    logic     req_prev;
    wb_exp_t  e;
    bus_exp_t b;
    run = 0; err_seen = 0; req_prev = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run = 0; err_seen = 0; req_prev = 0;
      end else begin
        if (bus_err_o) err_seen = 1;
        if (mem_req_o && !req_prev) begin
          if (bq.size() == 0) begin
            chk("unexpected_req", 1, 0);
          end else begin
            b = bq.pop_front();
            chk({b.name, "_we"}, mem_we_o, b.we);
            chk({b.name, "_addr"}, mem_addr_o, b.addr);
            chk({b.name, "_be"}, mem_be_o, b.be);
            if (b.we)
              chk({b.name, "_wdata"}, mem_wdata_o, b.wdata);
          end
        end
        req_prev = mem_req_o;
        if (stall_o) begin
          run++;
        end else if (wq.size() == 0) begin
          chk("unexpected_retire", 1, 0);
        end else begin
          e = wq.pop_front();
          chk({e.name, "_stalls"}, run, e.stalls);
          chk({e.name, "_wben"}, wb_en_o, e.en);
          chk({e.name, "_rd"}, wb_rd_o, e.rd);
          if (e.en)
            chk({e.name, "_data"}, wb_data_o, e.data);
          chk({e.name, "_misalign"}, misalign_o, e.mis);
          chk({e.name, "_buserr"}, err_seen, e.err);
          run = 0; err_seen = 0;
        end
      end
    end
  end

  task automatic finish_now();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  endtask

  // gd/rvd: grant delay in REQ cycles, rvalid delay after grant;
  // -1 means never
  task automatic issue(
      input logic re, input logic we,
      input logic [2:0] op, input logic [31:0] a,
      input logic [31:0] sd, input logic [31:0] res,
      input logic [4:0] r, input logic wbe,
      input int gd, input int rvd,
      input logic [31:0] rdw, input logic has_bus,
      input bus_exp_t bx, input wb_exp_t ex);
    int   reqc, since;
    logic granted, done;
    wq.push_back(ex);
    if (has_bus) bq.push_back(bx);
    @(posedge clk); #1;
    read_en = re; write_en = we; mem_op = op;
    addr = a; store_data = sd; result = res;
    rd = r; wb_en = wbe; rdata = rdw;
    reqc = 0; since = 0; granted = 0; done = 0;
    for (int c = 0; c < 300; c++) begin
      gnt = 0; rvalid = 0;
      if (granted) begin
        since++;
        if (rvd >= 0 && since == rvd) rvalid = 1;
      end else if (mem_req_o) begin
        if (gd >= 0 && reqc == gd) begin
          gnt = 1; granted = 1; since = 0;
          if (rvd == 0) rvalid = 1;
        end
        reqc++;
      end
      @(negedge clk);
      if (!stall_o) begin
        done = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      total_cnt++;
      $display("FAIL %s_hang: stall_o stuck at 1, required release",
               ex.name);
      finish_now();
    end
  endtask

  bus_exp_t nb;

  initial begin
    nb = B("none", 0, 0, 0, 0);
    rst = 1; result = 32'h55; wb_en = 1; rd = 5'd4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_wben", wb_en_o, 0);
    chk("rst_wbdata", wb_data_o, 0);
    chk("rst_misalign", misalign_o, 0);
    chk("rst_buserr", bus_err_o, 0);
    wq.push_back(W("idle0", 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst = 0; result = 0; wb_en = 0; rd = 0;

    issue(0, 0, 0, 0, 0, 32'h1234, 5, 1, 0, 0, 0, 0, nb,
          W("nonmem", 1, 5, 32'h1234, 0, 0, 0));
    issue(0, 1, MEM_B, 32'h1003, 32'hAABBCCDD, 0, 7, 1,
          0, -1, 0, 1,
          B("sb", 1, 32'h1000, 4'b1000, 32'hDDDDDDDD),
          W("sb", 0, 7, 0, 0, 0, 2));
    issue(1, 0, MEM_B, 32'h2002, 0, 0, 10, 1,
          0, 3, 32'h0080_0000, 1,
          B("lb", 0, 32'h2000, 4'b0100, 0),
          W("lb", 1, 10, 32'hFFFFFF80, 0, 0, 5));
    issue(1, 0, MEM_BU, 32'h2002, 0, 0, 11, 1,
          0, 3, 32'h0080_0000, 1,
          B("lbu", 0, 32'h2000, 4'b0100, 0),
          W("lbu", 1, 11, 32'h00000080, 0, 0, 5));
    issue(1, 0, MEM_H, 32'h3001, 0, 0, 12, 1,
          0, 0, 0, 0, nb,
          W("lh_mis", 0, 12, 0, 1, 0, 0));
    issue(0, 1, MEM_H, 32'h0000_0002, 32'h1234ABCD, 0, 0, 0,
          2, -1, 0, 1,
          B("sh", 1, 32'h0, 4'b1100, 32'hABCDABCD),
          W("sh", 0, 0, 0, 0, 0, 4));
    issue(0, 1, MEM_W, 32'h100, 32'h11223344, 0, 1, 1,
          0, -1, 0, 1,
          B("sw", 1, 32'h100, 4'b1111, 32'h11223344),
          W("sw", 0, 1, 0, 0, 0, 2));
    issue(1, 0, MEM_W, 32'h40, 0, 0, 9, 1,
          0, 0, 32'hDEADBEEF, 1,
          B("lw_same", 0, 32'h40, 4'b1111, 0),
          W("lw_same", 1, 9, 32'hDEADBEEF, 0, 0, 2));
    issue(1, 0, MEM_H, 32'h12, 0, 0, 13, 1,
          1, 1, 32'h8001_7FFF, 1,
          B("lh", 0, 32'h10, 4'b1100, 0),
          W("lh", 1, 13, 32'hFFFF8001, 0, 0, 4));
    issue(1, 0, MEM_HU, 32'h12, 0, 0, 14, 1,
          1, 1, 32'h8001_7FFF, 1,
          B("lhu", 0, 32'h10, 4'b1100, 0),
          W("lhu", 1, 14, 32'h00008001, 0, 0, 4));
    issue(1, 0, MEM_H, 32'h20, 0, 0, 16, 1,
          0, 1, 32'h8001_7FFF, 1,
          B("lh_lo", 0, 32'h20, 4'b0011, 0),
          W("lh_lo", 1, 16, 32'h00007FFF, 0, 0, 3));
    issue(1, 1, MEM_W, 32'h0, 0, 0, 2, 1,
          0, 0, 0, 0, nb,
          W("rw_both", 0, 2, 0, 1, 0, 0));
    issue(0, 1, MEM_BU, 32'h0, 0, 0, 3, 1,
          0, 0, 0, 0, nb,
          W("st_bu", 0, 3, 0, 1, 0, 0));
    issue(1, 0, 3'b011, 32'h0, 0, 0, 4, 1,
          0, 0, 0, 0, nb,
          W("ld_011", 0, 4, 0, 1, 0, 0));
    issue(1, 0, MEM_W, 32'h6, 0, 0, 8, 1,
          0, 0, 0, 0, nb,
          W("lw_mis", 0, 8, 0, 1, 0, 0));
    issue(1, 0, MEM_W, 32'h44, 0, 0, 17, 0,
          0, 0, 32'h5, 1,
          B("lw_nowb", 0, 32'h44, 4'b1111, 0),
          W("lw_nowb", 0, 17, 0, 0, 0, 2));
    issue(1, 0, MEM_W, 32'h48, 0, 0, 15, 1,
          0, -1, 32'h77, 1,
          B("tmo_wait", 0, 32'h48, 4'b1111, 0),
          W("tmo_wait", 0, 15, 0, 0, 1, 65));
    issue(0, 1, MEM_W, 32'h4C, 32'hCAFEF00D, 0, 18, 1,
          -1, -1, 0, 1,
          B("tmo_req", 1, 32'h4C, 4'b1111, 32'hCAFEF00D),
          W("tmo_req", 0, 18, 0, 0, 1, 65));

    // reset while a load waits for rvalid, then a late rvalid
    bq.push_back(B("rst_lw", 0, 32'h80, 4'b1111, 0));
    @(posedge clk); #1;
    read_en = 1; write_en = 0; mem_op = MEM_W;
    addr = 32'h80; rd = 6; wb_en = 1; gnt = 0; rvalid = 0;
    @(posedge clk); #1;
    gnt = 1;
    @(posedge clk); #1;
    gnt = 0; rst = 1;
    read_en = 0; mem_op = 0; addr = 0; rd = 0; wb_en = 0;
    wq.push_back(W("post_rst", 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst = 0; rvalid = 1; rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("post_rst_stall", stall_o, 0);
    chk("post_rst_req", mem_req_o, 0);
    chk("post_rst_wbdata", wb_data_o, 0);
    chk("post_rst_addr", mem_addr_o, 0);
    chk("post_rst_be", mem_be_o, 0);
    issue(0, 0, 0, 0, 0, 32'hCAFE, 3, 1, 0, 0, 0, 0, nb,
          W("after_rst", 1, 3, 32'hCAFE, 0, 0, 0));

    wq.push_back(W("tail", 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    read_en = 0; write_en = 0; result = 0; rd = 0; wb_en = 0;
    gnt = 0; rvalid = 0;
    @(negedge clk); #1;
    chk("wq_empty", wq.size(), 0);
    chk("bq_empty", bq.size(), 0);
    finish_now();
  end

endmodule
